// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared defaults and constants for the instruction queue
package iq_pkg;

   // Default geometry: 8-bit instruction words, 4-bit opcode, 4 entries
   localparam int IQ_DATA_W = 8;
   localparam int IQ_OPC_W  = 4;
   localparam int IQ_DEPTH  = 4;

   // Opcode presented to the control unit when no instruction is queued
   localparam int OPC_NOP   = 0;

   // Width of an occupancy counter able to hold 0..depth inclusive
   function automatic int iq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - push/pop strobes and status bundle of the instruction queue
interface iq_if
   import iq_pkg::*;
#(
   parameter int DATA_W = IQ_DATA_W,
   parameter int OPC_W  = IQ_OPC_W,
   parameter int DEPTH  = IQ_DEPTH
);
   // Bus side: active-low push, active-high pop, active-low operand drive
   logic                        load;
   logic [DATA_W-1:0]           data;
   logic                        advance;
   logic                        enable;

   // Queue side: head opcode and occupancy status
   logic [OPC_W-1:0]            opcode;
   logic [$clog2(DEPTH):0]      count;
   logic                        full;
   logic                        empty;
   logic                        ovf;
   logic                        udf;

   // Producer of strobes (bus / control unit)
   modport master (
      output load, data, advance, enable,
      input  opcode, count, full, empty, ovf, udf
   );

   // The queue itself
   modport slave (
      input  load, data, advance, enable,
      output opcode, count, full, empty, ovf, udf
   );

endinterface

// File: rtl/iq_mem.sv
// rtl/iq_mem.sv - DEPTH x DATA_W register array, one write port, async read, no reset
module iq_mem
   import iq_pkg::*;
#(
   parameter int DATA_W = IQ_DATA_W,
   parameter int DEPTH  = IQ_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
)(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the tail entry; contents deliberately survive reset
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - instruction prefetch queue with head decode and tri-state operand bus
module instruction_queue
   import iq_pkg::*;
#(
   parameter int DATA_W = IQ_DATA_W,
   parameter int OPC_W  = IQ_OPC_W,
   parameter int DEPTH  = IQ_DEPTH
)(
   input  logic                    clk,
   input  logic                    clr,
   iq_if.slave                     bus,
   output wire [DATA_W-OPC_W-1:0]  q
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = iq_cnt_w(DEPTH);
   localparam int OPR_W = DATA_W - OPC_W;

   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;
   logic              r_udf;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_ovf_evt;
   logic              w_udf_evt;
   logic [DATA_W-1:0] w_head;
   logic [OPR_W-1:0]  w_opr;

   // Flags come straight from the counter so they can never disagree with it
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);

   // A pop while full frees the slot the simultaneous push lands in
   assign w_push    = ~bus.load & (~w_full | bus.advance);
   assign w_pop     = bus.advance & ~w_empty;

   // A push is lost only when full and nothing retires this edge
   assign w_ovf_evt = ~bus.load & w_full & ~bus.advance;
   // Asking for an instruction that is not there, even with one arriving
   assign w_udf_evt = bus.advance & w_empty;

   iq_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata (bus.data),
      .i_raddr (r_rptr),
      .o_rdata (w_head)
   );

   // Pointers, occupancy and sticky error flags
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end
         if (w_udf_evt) begin
            r_udf <= 1'b1;
         end
      end
   end

   // Stale array contents are masked to NOP/zero whenever nothing is queued
   assign bus.opcode = w_empty ? OPC_W'(OPC_NOP) : w_head[DATA_W-1 -: OPC_W];
   assign w_opr      = w_empty ? '0 : w_head[OPR_W-1:0];

   // Operand bus released purely by enable, regardless of clock or reset
   assign q          = bus.enable ? {OPR_W{1'bz}} : w_opr;

   assign bus.count  = r_count;
   assign bus.full   = w_full;
   assign bus.empty  = w_empty;
   assign bus.ovf    = r_ovf;
   assign bus.udf    = r_udf;

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard bench for instruction_queue
`timescale 1ns/1ps
module tb_instruction_queue;

   logic       clk;
   logic       clr;
   wire  [3:0] w_q;

   iq_if #(.DATA_W(8), .OPC_W(4), .DEPTH(4)) bus ();

   instruction_queue #(.DATA_W(8), .OPC_W(4), .DEPTH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus),
      .q   (w_q)
   );

   // Released operand bus floats up, so high-impedance reads as all ones
   pullup (w_q[0]);
   pullup (w_q[1]);
   pullup (w_q[2]);
   pullup (w_q[3]);

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] model [$];
   logic [7:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; popped words are queued for the monitor
   task automatic cycle(input logic ld_n, input logic [7:0] d, input logic adv);
      bit do_pop;
      bit do_push;
      @(negedge clk);
      #1;
      bus.load    = ld_n;
      bus.data    = d;
      bus.advance = adv;
      do_pop  = adv && (model.size() > 0);
      do_push = !ld_n && ((model.size() < 4) || adv);
      if (do_pop)  exp_q.push_back(model.pop_front());
      if (do_push) model.push_back(d);
      @(posedge clk);
      #1;
      bus.load    = 1'b1;
      bus.advance = 1'b0;
   endtask

   // Monitor: whenever a pop is about to retire the head, compare it to the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (bus.advance === 1'b1 && bus.empty === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL pop_unexpected: got %0h expected none", {bus.opcode, w_q});
            end else begin
               chk("pop_word", {24'd0, bus.opcode, w_q}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr         = 1'b0;
      bus.load    = 1'b1;
      bus.data    = 8'h00;
      bus.advance = 1'b0;
      bus.enable  = 1'b0;
      #2;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      chk("rst_opc",   32'(bus.opcode), 32'd0);
      chk("rst_q",     32'(w_q), 32'd0);
      #1;
      clr      = 1'b1;
      bus.load = 1'b0;
      bus.data = 8'hAA;
      #4;
      bus.load = 1'b1;
      chk("pre_clr_count", 32'(bus.count), 32'd1);
      chk("pre_clr_opc",   32'(bus.opcode), 32'hA);
      #5;
      clr = 1'b0;
      #1;
      chk("clr_mid_count", 32'(bus.count), 32'd0);
      chk("clr_mid_empty", 32'(bus.empty), 32'd1);
      chk("clr_mid_opc",   32'(bus.opcode), 32'd0);
      #1;
      clr = 1'b1;

      // Single push, head decode and bus release
      cycle(1'b0, 8'hF5, 1'b0);
      chk("f5_opc",   32'(bus.opcode), 32'hF);
      chk("f5_q",     32'(w_q), 32'h5);
      chk("f5_count", 32'(bus.count), 32'd1);
      bus.enable = 1'b1;
      #1;
      chk("f5_q_hiz", 32'(w_q), 32'hF);
      bus.enable = 1'b0;
      cycle(1'b1, 8'h00, 1'b1);
      chk("f5_pop_empty", 32'(bus.empty), 32'd1);
      chk("f5_pop_opc",   32'(bus.opcode), 32'd0);
      chk("f5_pop_q",     32'(w_q), 32'd0);

      // Fill, then overflow
      cycle(1'b0, 8'h11, 1'b0);
      cycle(1'b0, 8'h22, 1'b0);
      cycle(1'b0, 8'h33, 1'b0);
      cycle(1'b0, 8'h44, 1'b0);
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_ovf0", 32'(bus.ovf),  32'd0);
      cycle(1'b0, 8'h55, 1'b0);
      chk("ovf_set",   32'(bus.ovf),   32'd1);
      chk("ovf_count", 32'(bus.count), 32'd4);
      chk("ovf_head",  32'({bus.opcode, w_q}), 32'h11);

      // Push and pop together while full
      cycle(1'b0, 8'h66, 1'b1);
      chk("fullpp_count", 32'(bus.count), 32'd4);
      chk("fullpp_head",  32'({bus.opcode, w_q}), 32'h22);
      repeat (4) cycle(1'b1, 8'h00, 1'b1);
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("drain_udf0",  32'(bus.udf),   32'd0);

      // Underflow, then push and pop together while empty
      cycle(1'b1, 8'h00, 1'b1);
      chk("udf_set",   32'(bus.udf),   32'd1);
      chk("udf_count", 32'(bus.count), 32'd0);
      cycle(1'b0, 8'h0F, 1'b1);
      chk("emptypp_count", 32'(bus.count),  32'd1);
      chk("emptypp_opc",   32'(bus.opcode), 32'd0);
      chk("emptypp_q",     32'(w_q), 32'hF);
      cycle(1'b1, 8'h00, 1'b1);

      // Ten interleaved operations around the pointer wrap
      for (int i = 0; i < 10; i++) begin
         logic [7:0] d;
         d = {4'(i + 1), 4'(9 - i)};
         if (i % 4 == 3)      cycle(1'b1, d, 1'b1);
         else if (i % 2 == 1) cycle(1'b0, d, 1'b1);
         else                 cycle(1'b0, d, 1'b0);
      end
      chk("wrap_count", 32'(bus.count), 32'd3);
      repeat (3) cycle(1'b1, 8'h00, 1'b1);
      chk("wrap_empty",  32'(bus.empty), 32'd1);
      chk("sticky_ovf",  32'(bus.ovf), 32'd1);
      chk("sticky_udf",  32'(bus.udf), 32'd1);

      // Reset mid-operation discards entries and flags
      cycle(1'b0, 8'hC1, 1'b0);
      cycle(1'b0, 8'hC2, 1'b0);
      @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      chk("midrst_count", 32'(bus.count), 32'd0);
      chk("midrst_ovf",   32'(bus.ovf), 32'd0);
      chk("midrst_udf",   32'(bus.udf), 32'd0);
      bus.enable = 1'b1;
      #1;
      chk("midrst_q_hiz", 32'(w_q), 32'hF);
      bus.enable = 1'b0;
      clr = 1'b1;
      model.delete();
      cycle(1'b0, 8'hD7, 1'b0);
      chk("postrst_count", 32'(bus.count), 32'd1);
      chk("postrst_head",  32'({bus.opcode, w_q}), 32'hD7);
      cycle(1'b1, 8'h00, 1'b1);
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
